// File: rtl/exec_ctrl.sv
// Multi-cycle instruction sequencer for the 8-bit uProcessor core: fetch over req/ack,
// decode, drive the shared combinational ALU, and own pc, acc, carry and the register file.

`ifndef ALU_LD
`define ALU_LD  3'd0
`define ALU_ADD 3'd1
`define ALU_SUB 3'd2
`define ALU_AND 3'd3
`define ALU_OR  3'd4
`define ALU_XOR 3'd5
`define ALU_NOT 3'd6
`endif

module exec_ctrl (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] imem_addr,
    output logic       imem_req,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic [2:0] alu_code,
    output logic [7:0] alu_a,
    output logic [7:0] alu_r,
    output logic       alu_ci,
    input  logic [7:0] alu_out,
    input  logic       alu_co,
    output logic [7:0] acc,
    output logic       carry,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_FETCH_IMM,
        S_EXEC,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADC  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_SBC  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_LDI  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_NOPE = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] acc_q, acc_d;
    logic       carry_q, carry_d;
    logic [7:0] rf_q [8];
    logic       rf_we;

    logic [3:0] opcode;
    logic [2:0] ridx;
    logic       ir_bit3_unused;

    assign opcode         = ir_q[7:4];
    assign ridx           = ir_q[2:0];
    assign ir_bit3_unused = ir_q[3];

    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        case (op)
            OP_ADD, OP_ADC: alu_sel = `ALU_ADD;
            OP_SUB, OP_SBC: alu_sel = `ALU_SUB;
            OP_AND:         alu_sel = `ALU_AND;
            OP_OR:          alu_sel = `ALU_OR;
            OP_XOR:         alu_sel = `ALU_XOR;
            OP_NOT:         alu_sel = `ALU_NOT;
            default:        alu_sel = `ALU_LD;
        endcase
    endfunction

    function automatic logic uses_carry_in(input logic [3:0] op);
        uses_carry_in = (op == OP_ADC) || (op == OP_SBC);
    endfunction

    assign imem_addr = pc_q;
    assign alu_a     = acc_q;
    assign alu_r     = rf_q[ridx];
    assign acc       = acc_q;
    assign carry     = carry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
            acc_q   <= 8'h00;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 8'h00;
            end
        end else if (rf_we) begin
            rf_q[ridx] <= acc_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        rf_we    = 1'b0;
        imem_req = 1'b0;
        halted   = 1'b0;
        alu_code = `ALU_LD;
        alu_ci   = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + 8'd1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                case (opcode)
                    OP_LDI, OP_JMP, OP_JC: state_d = S_FETCH_IMM;
                    OP_HALT:               state_d = S_HALTED;
                    OP_ST: begin
                        rf_we   = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_NOP, OP_NOPE:       state_d = S_FETCH;
                    default:               state_d = S_EXEC;
                endcase
            end

            S_FETCH_IMM: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    pc_d = pc_q + 8'd1;
                    // JC looks at the carry left by earlier instructions, never this one.
                    if (opcode == OP_LDI) begin
                        acc_d = imem_data;
                    end else if (opcode == OP_JMP || (opcode == OP_JC && carry_q)) begin
                        pc_d = imem_data;
                    end
                    state_d = S_FETCH;
                end
            end

            S_EXEC: begin
                alu_code = alu_sel(opcode);
                alu_ci   = uses_carry_in(opcode) ? carry_q : 1'b0;
                acc_d    = alu_out;
                carry_d  = alu_co;
                state_d  = S_FETCH;
            end

            S_HALTED: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule
